// File: rtl/data_ram_bank.sv
// Single-port byte-enabled data RAM behind a valid/ready request/response pair.
// Optional per-byte even parity with error injection when DATA_RAM_PARITY_EN is defined.
module data_ram_bank #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter     BASE_ADDR = 32'h0001_0000,
  parameter int ADDR_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_sel,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   dbg_word
`ifdef DATA_RAM_PARITY_EN
  ,
  input  logic                inj_par_err,
  output logic                par_err_sticky
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   SPAN = (ADDR_W + 1)'(DEPTH * BYTES);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              accept;
  logic              req_err;

  // Offset is compared with one extra bit so the span limit cannot wrap.
  assign offset    = req_addr - BASE;
  assign idx       = offset[OFF_W +: IDX_W];
  assign in_range  = (req_addr >= BASE) && ({1'b0, offset} < SPAN);
  assign req_ready = (!rsp_valid || rsp_ready) && !rst;
  assign accept    = req_valid && req_ready;
  assign dbg_word  = mem[0];

  always_ff @(posedge clk) begin
    if (accept && req_we && in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_sel[b]) begin
          mem[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
        end
      end
    end
  end

`ifdef DATA_RAM_PARITY_EN
  logic [BYTES-1:0] par_mem [DEPTH];
  logic             par_bad;

  // Stored parity bit makes each byte plus its bit XOR to zero unless injected.
  always_ff @(posedge clk) begin
    if (accept && req_we && in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_sel[b]) begin
          par_mem[idx][b] <= (^req_wdata[b*8 +: 8]) ^ inj_par_err;
        end
      end
    end
  end

  always_comb begin
    par_bad = 1'b0;
    for (int b = 0; b < BYTES; b++) begin
      if ((^mem[idx][b*8 +: 8]) != par_mem[idx][b]) begin
        par_bad = 1'b1;
      end
    end
  end

  assign req_err = !in_range || (!req_we && par_bad);

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_sticky <= 1'b0;
    end else if (accept && !req_we && in_range && par_bad) begin
      par_err_sticky <= 1'b1;
    end
  end
`else
  assign req_err = !in_range;
`endif

  // Response register: replaced on accept, dropped when consumed with nothing new.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= (!req_we && in_range) ? mem[idx] : '0;
      rsp_err   <= req_err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_ram_bank.sv
// Directed self-checking bench for data_ram_bank with default parameters.
// Parity checks are included when DATA_RAM_PARITY_EN is defined.
module tb_data_ram_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dbg_word;
`ifdef DATA_RAM_PARITY_EN
  logic        inj_par_err;
  logic        par_err_sticky;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  data_ram_bank dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_sel   (req_sel),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dbg_word  (dbg_word)
`ifdef DATA_RAM_PARITY_EN
    ,
    .inj_par_err    (inj_par_err),
    .par_err_sticky (par_err_sticky)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request with the response consumer ready; response is visible on return.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_sel   = sel;
    req_wdata = wdata;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic checkRsp(input string tag, input logic [31:0] rdata, input logic err);
    checkOutput({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    checkOutput({tag, "_rdata"}, rsp_rdata, rdata);
    checkOutput({tag, "_err"}, {31'b0, rsp_err}, {31'b0, err});
  endtask

  logic [31:0] burstAddr [4];
  logic [31:0] burstData [4];

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_sel = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
`ifdef DATA_RAM_PARITY_EN
    inj_par_err = 1'b0;
`endif
    tick();
    tick();
    checkOutput("rst_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_req_ready", {31'b0, req_ready}, 32'd1);

    applyStimulus(1'b1, 32'h0001_0004, 4'hF, 32'hDEAD_BEEF);
    checkRsp("wr_deadbeef", 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0001_0004, 4'hF, 32'h0);
    checkRsp("rd_deadbeef", 32'hDEAD_BEEF, 1'b0);

    applyStimulus(1'b1, 32'h0001_0000, 4'hF, 32'h1122_3344);
    checkOutput("dbg_full", dbg_word, 32'h1122_3344);
    applyStimulus(1'b1, 32'h0001_0000, 4'b0101, 32'hAABB_CCDD);
    checkOutput("dbg_partial", dbg_word, 32'h11BB_33DD);
    applyStimulus(1'b0, 32'h0001_0000, 4'hF, 32'h0);
    checkRsp("rd_partial", 32'h11BB_33DD, 1'b0);

    applyStimulus(1'b0, 32'h0000_FFFC, 4'hF, 32'h0);
    checkRsp("rd_below", 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0001_1000, 4'hF, 32'h0);
    checkRsp("rd_above", 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h0001_1000, 4'hF, 32'h0);
    checkRsp("wr_above", 32'h0, 1'b1);
    checkOutput("dbg_after_oor", dbg_word, 32'h11BB_33DD);
    applyStimulus(1'b1, 32'h0001_1004, 4'hF, 32'h0);
    applyStimulus(1'b0, 32'h0001_0004, 4'hF, 32'h0);
    checkRsp("rd_after_oor", 32'hDEAD_BEEF, 1'b0);

    applyStimulus(1'b1, 32'h0001_0FFC, 4'hF, 32'h5A5A_1234);
    checkRsp("wr_last", 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0001_0FFC, 4'hF, 32'h0);
    checkRsp("rd_last", 32'h5A5A_1234, 1'b0);

    applyStimulus(1'b0, 32'h0001_0000, 4'h0, 32'h0);
    checkRsp("rd_sel0", 32'h11BB_33DD, 1'b0);
    applyStimulus(1'b1, 32'h0001_0000, 4'h0, 32'hFFFF_FFFF);
    checkRsp("wr_sel0", 32'h0, 1'b0);
    checkOutput("dbg_sel0", dbg_word, 32'h11BB_33DD);

    applyStimulus(1'b0, 32'h0001_0007, 4'hF, 32'h0);
    checkRsp("rd_lowbits", 32'hDEAD_BEEF, 1'b0);

    // Write then read of the same word on consecutive edges.
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h0001_0008;
    req_sel = 4'hF;
    req_wdata = 32'hCAFE_F00D;
    rsp_ready = 1'b1;
    tick();
    checkRsp("b2b_wr", 32'h0, 1'b0);
    req_we = 1'b0;
    tick();
    checkRsp("b2b_rd", 32'hCAFE_F00D, 1'b0);
    req_valid = 1'b0;
    tick();
    checkOutput("drain_valid", {31'b0, rsp_valid}, 32'd0);

    // Backpressure: pending response must hold and block new requests.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h0001_0004;
    tick();
    checkRsp("bp_first", 32'hDEAD_BEEF, 1'b0);
    req_addr = 32'h0001_0000;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
      tick();
      checkRsp("bp_hold", 32'hDEAD_BEEF, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'b0, req_ready}, 32'd1);
    burstAddr[0] = 32'h0001_0000; burstData[0] = 32'h11BB_33DD;
    burstAddr[1] = 32'h0001_0004; burstData[1] = 32'hDEAD_BEEF;
    burstAddr[2] = 32'h0001_0008; burstData[2] = 32'hCAFE_F00D;
    burstAddr[3] = 32'h0001_0FFC; burstData[3] = 32'h5A5A_1234;
    for (int i = 0; i < 4; i++) begin
      req_addr = burstAddr[i];
      tick();
      checkRsp("burst", burstData[i], 1'b0);
    end
    req_valid = 1'b0;
    tick();
    checkOutput("burst_end_valid", {31'b0, rsp_valid}, 32'd0);

    // Reset with a pending response and a write request present.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h0001_0000;
    tick();
    checkRsp("pend", 32'h11BB_33DD, 1'b0);
    rst = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h0001_0004;
    req_sel = 4'hF;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;
    #1;
    checkOutput("rst_blocks_ready", {31'b0, req_ready}, 32'd0);
    tick();
    checkOutput("rst2_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst2_rdata", rsp_rdata, 32'd0);
    checkOutput("rst2_err", {31'b0, rsp_err}, 32'd0);
    rst = 1'b0;
    req_valid = 1'b0;
    applyStimulus(1'b0, 32'h0001_0004, 4'hF, 32'h0);
    checkRsp("rd_after_rst", 32'hDEAD_BEEF, 1'b0);

`ifdef DATA_RAM_PARITY_EN
    checkOutput("par_sticky_init", {31'b0, par_err_sticky}, 32'd0);
    inj_par_err = 1'b1;
    applyStimulus(1'b1, 32'h0001_000C, 4'hF, 32'h0);
    inj_par_err = 1'b0;
    checkRsp("par_wr", 32'h0, 1'b0);
    checkOutput("par_sticky_wr", {31'b0, par_err_sticky}, 32'd0);
    applyStimulus(1'b0, 32'h0001_000C, 4'hF, 32'h0);
    checkRsp("par_rd_bad", 32'h0, 1'b1);
    checkOutput("par_sticky_set", {31'b0, par_err_sticky}, 32'd1);
    applyStimulus(1'b0, 32'h0001_0004, 4'hF, 32'h0);
    checkRsp("par_rd_good", 32'hDEAD_BEEF, 1'b0);
    checkOutput("par_sticky_hold", {31'b0, par_err_sticky}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("par_sticky_clr", {31'b0, par_err_sticky}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
